// File: rtl/psg_multi.sv
// psg_multi: multi-channel programmable sound generator.
// It has CHANNELS square-wave tone generators, one shared 17-bit LFSR noise
// source, a tone/noise mixer for each channel, and a 4-bit amplitude for each
// channel. The optional hardware envelope is built only when PSG_ENV_EN is
// defined.
//
// Ports:
//   CLK         system clock
//   RESET_N     asynchronous active-low reset
//   CE          clock enable; all generator timing advances only on CE
//   BDIR, BC    bus strobes: 11 latch address, 10 write, 01 read, 00 idle
//   DI          write data / register address
//   DO          registered read data
//   CHANNEL_OUT channel i level at [8i+7:8i] (level*17 when gated on)
//   ACTIVE      bit i set when channel i output is nonzero
module psg_multi #(
  parameter int CHANNELS = 3,
  parameter int TONE_W   = 12,
  parameter int PRESCALE = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CE,
  input  logic                  BDIR,
  input  logic                  BC,
  input  logic [7:0]            DI,
  output logic [7:0]            DO,
  output logic [8*CHANNELS-1:0] CHANNEL_OUT,
  output logic [CHANNELS-1:0]   ACTIVE
);

  // The prescaler wraps every 2*PRESCALE CE pulses. A tone tick fires when
  // the low half of the prescaler wraps. A noise/envelope tick fires when
  // the whole prescaler wraps.
  localparam int PW = $clog2(2 * PRESCALE);

  logic [7:0]          addr_q, addr_d, do_q, do_d, rd_data;
  logic [TONE_W-1:0]   tone_per_q [CHANNELS];
  logic [TONE_W-1:0]   tone_per_d [CHANNELS];
  logic [TONE_W-1:0]   tone_cnt_q [CHANNELS];
  logic [TONE_W-1:0]   tone_cnt_d [CHANNELS];
  logic [4:0]          amp_q [CHANNELS];
  logic [4:0]          amp_d [CHANNELS];
  logic [CHANNELS-1:0] tone_q, tone_d, tone_dis_q, tone_dis_d, noise_dis_q, noise_dis_d;
  logic [4:0]          noise_per_q, noise_per_d, noise_cnt_q, noise_cnt_d;
  logic [16:0]         lfsr_q, lfsr_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [8*CHANNELS-1:0] chan_out_q, chan_out_d;
  logic [CHANNELS-1:0] active_q, active_d;
  logic                tone_tick, noise_tick, wr_en;
  logic [3:0]          lvl;
  logic                gate;

`ifdef PSG_ENV_EN
  logic [15:0] env_per_q, env_per_d, env_cnt_q, env_cnt_d;
  logic [3:0]  env_shape_q, env_shape_d, env_step_q, env_step_d;
  logic [3:0]  env_hold_lvl_q, env_hold_lvl_d, env_level;
  logic        env_att_q, env_att_d, env_hold_q, env_hold_d;

  // While the envelope is held, the hold level wins. Otherwise the level
  // rises (ATT) or falls from the current step.
  assign env_level = env_hold_q ? env_hold_lvl_q : (env_att_q ? env_step_q : ~env_step_q);
`endif

  function automatic logic [7:0] hi_byte(input logic [TONE_W-1:0] p);
    logic [15:0] ext;
    ext = 16'(p);
    return ext[15:8];
  endfunction

  // Period 0 behaves like period 1. The counter wraps at period-1.
  function automatic logic [TONE_W-1:0] tone_lim(input logic [TONE_W-1:0] p);
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

  assign wr_en = BDIR & ~BC;

  // Read mux. Unmapped addresses and channels that do not exist return 0.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      if (addr_q == 8'(2 * i))     rd_data = tone_per_q[i][7:0];
      if (addr_q == 8'(2 * i + 1)) rd_data = hi_byte(tone_per_q[i]);
      if (addr_q == 8'(48 + i))    rd_data = {3'b000, amp_q[i]};
    end
    case (addr_q)
      8'h20:   rd_data = {3'b000, noise_per_q};
      8'h22:   rd_data = 8'(tone_dis_q);
      8'h23:   rd_data = 8'(noise_dis_q);
`ifdef PSG_ENV_EN
      8'h40:   rd_data = env_per_q[7:0];
      8'h41:   rd_data = env_per_q[15:8];
      8'h42:   rd_data = {4'h0, env_shape_q};
`endif
      default: ;
    endcase
  end

  // Next state: bus, prescaler, generators, then register writes. Register
  // writes come last so that an envelope shape write overrides an envelope
  // tick on the same edge.
  always_comb begin
    // NOTE: every _d starts from its _q, so no path can leave a value unassigned and infer a latch.
    addr_d      = addr_q;
    do_d        = do_q;
    tone_per_d  = tone_per_q;
    tone_cnt_d  = tone_cnt_q;
    amp_d       = amp_q;
    tone_d      = tone_q;
    tone_dis_d  = tone_dis_q;
    noise_dis_d = noise_dis_q;
    noise_per_d = noise_per_q;
    noise_cnt_d = noise_cnt_q;
    lfsr_d      = lfsr_q;
    pre_d       = pre_q;
    tone_tick   = 1'b0;
    noise_tick  = 1'b0;
`ifdef PSG_ENV_EN
    env_per_d      = env_per_q;
    env_cnt_d      = env_cnt_q;
    env_shape_d    = env_shape_q;
    env_step_d     = env_step_q;
    env_hold_lvl_d = env_hold_lvl_q;
    env_att_d      = env_att_q;
    env_hold_d     = env_hold_q;
`endif

    if (BDIR && BC) addr_d = DI;
    if (!BDIR && BC) do_d = rd_data;

    if (CE) begin
      pre_d      = pre_q + 1'b1;
      tone_tick  = &pre_q[PW-2:0];
      noise_tick = &pre_q;
    end

    // The tone counters are not cleared on a period write. A counter that is
    // already past a shorter new period wraps on its next tick.
    for (int i = 0; i < CHANNELS; i++) begin
      if (tone_tick) begin
        if (tone_cnt_q[i] >= tone_lim(tone_per_q[i])) begin
          tone_cnt_d[i] = '0;
          tone_d[i]     = ~tone_q[i];
        end else begin
          tone_cnt_d[i] = tone_cnt_q[i] + 1'b1;
        end
      end
    end

    if (noise_tick) begin
      if (noise_cnt_q >= ((noise_per_q == 5'd0) ? 5'd0 : noise_per_q - 5'd1)) begin
        noise_cnt_d = 5'd0;
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
      end else begin
        noise_cnt_d = noise_cnt_q + 5'd1;
      end
    end

`ifdef PSG_ENV_EN
    if (noise_tick) begin
      if (env_cnt_q >= ((env_per_q == 16'd0) ? 16'd0 : env_per_q - 16'd1)) begin
        env_cnt_d = 16'd0;
        if (!env_hold_q) begin
          if (env_step_q != 4'hF) begin
            env_step_d = env_step_q + 4'd1;
          end else if (!env_shape_q[3]) begin
            env_hold_d     = 1'b1;
            env_hold_lvl_d = 4'h0;
          end else if (env_shape_q[0]) begin
            // Hold the final level of this cycle, inverted when ALT is set.
            env_hold_d     = 1'b1;
            env_hold_lvl_d = {4{env_att_q}} ^ {4{env_shape_q[1]}};
          end else begin
            env_step_d = 4'h0;
            if (env_shape_q[1]) env_att_d = ~env_att_q;
          end
        end
      end else begin
        env_cnt_d = env_cnt_q + 16'd1;
      end
    end
`endif

    if (wr_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (addr_q == 8'(2 * i))     tone_per_d[i] = {tone_per_q[i][TONE_W-1:8], DI};
        if (addr_q == 8'(2 * i + 1)) tone_per_d[i] = TONE_W'({DI, tone_per_q[i][7:0]});
        if (addr_q == 8'(48 + i))    amp_d[i] = DI[4:0];
      end
      case (addr_q)
        8'h20: noise_per_d = DI[4:0];
        8'h22: tone_dis_d  = DI[CHANNELS-1:0];
        8'h23: noise_dis_d = DI[CHANNELS-1:0];
`ifdef PSG_ENV_EN
        8'h40: env_per_d[7:0]  = DI;
        8'h41: env_per_d[15:8] = DI;
        8'h42: begin
          env_shape_d = DI[3:0];
          env_cnt_d   = 16'd0;
          env_step_d  = 4'h0;
          env_hold_d  = 1'b0;
          env_att_d   = DI[2];
        end
`endif
        default: ;
      endcase
    end
  end

  // Mixer. The outputs are registered, so they lag the gate/level by one CLK.
  always_comb begin
    chan_out_d = '0;
    active_d   = '0;
    lvl        = 4'h0;
    gate       = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      gate = (tone_q[i] | tone_dis_q[i]) & (lfsr_q[0] | noise_dis_q[i]);
`ifdef PSG_ENV_EN
      lvl  = amp_q[i][4] ? env_level : amp_q[i][3:0];
`else
      lvl  = amp_q[i][3:0];
`endif
      chan_out_d[8*i +: 8] = gate ? {lvl, lvl} : 8'h00;
      active_d[i]          = gate && (lvl != 4'h0);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the register file has defined reset values, so it is reset like any other flop.
      addr_q      <= 8'h00;
      do_q        <= 8'h00;
      tone_per_q  <= '{default: '0};
      tone_cnt_q  <= '{default: '0};
      amp_q       <= '{default: '0};
      tone_q      <= '0;
      tone_dis_q  <= '1;
      noise_dis_q <= '1;
      noise_per_q <= 5'd0;
      noise_cnt_q <= 5'd0;
      lfsr_q      <= 17'h00001;
      pre_q       <= '0;
      chan_out_q  <= '0;
      active_q    <= '0;
`ifdef PSG_ENV_EN
      env_per_q      <= 16'd0;
      env_cnt_q      <= 16'd0;
      env_shape_q    <= 4'h0;
      env_step_q     <= 4'h0;
      env_hold_lvl_q <= 4'h0;
      env_att_q      <= 1'b0;
      env_hold_q     <= 1'b1;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
      addr_q      <= addr_d;
      do_q        <= do_d;
      tone_per_q  <= tone_per_d;
      tone_cnt_q  <= tone_cnt_d;
      amp_q       <= amp_d;
      tone_q      <= tone_d;
      tone_dis_q  <= tone_dis_d;
      noise_dis_q <= noise_dis_d;
      noise_per_q <= noise_per_d;
      noise_cnt_q <= noise_cnt_d;
      lfsr_q      <= lfsr_d;
      pre_q       <= pre_d;
      chan_out_q  <= chan_out_d;
      active_q    <= active_d;
`ifdef PSG_ENV_EN
      env_per_q      <= env_per_d;
      env_cnt_q      <= env_cnt_d;
      env_shape_q    <= env_shape_d;
      env_step_q     <= env_step_d;
      env_hold_lvl_q <= env_hold_lvl_d;
      env_att_q      <= env_att_d;
      env_hold_q     <= env_hold_d;
`endif
    end
  end

  assign DO          = do_q;
  assign CHANNEL_OUT = chan_out_q;
  assign ACTIVE      = active_q;

endmodule
